// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg
// Shared constants and types for the DDR command issuer slice:
//   APP_CMD_WR / APP_CMD_RD : controller native command encodings
//   ADDR_W / BURST_W / DATA_W / MASK_W : command field widths
//   issuer_state_t : issuer FSM states
package ddr_cmd_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int ADDR_W  = 27;
  localparam int BURST_W = 6;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = 16;

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WDATA    = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/ddr_cmd_issuer_if.sv
// ddr_cmd_issuer_if
// Bundles the command-FIFO pop side, the DDR3 controller native
// command/write/read channels and the user read-return channel.
//   master : the issuer (pops the FIFO, drives the controller)
//   slave  : the environment (FIFO + controller + read consumer)
interface ddr_cmd_issuer_if;
  import ddr_cmd_pkg::*;

  // command FIFO pop side
  logic                cmd_valid;
  logic                cmd_rdy;
  logic                cmd_type;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BURST_W-1:0]  cmd_burst_cnt;
  logic [DATA_W-1:0]   cmd_wt_data;
  logic [MASK_W-1:0]   cmd_wt_mask;
  // controller command channel
  logic [2:0]          app_cmd;
  logic                app_cmd_en;
  logic [ADDR_W-1:0]   app_addr;
  logic [BURST_W-1:0]  app_burst_number;
  logic                app_cmd_rdy;
  // controller write-data channel
  logic                app_wr_en;
  logic                app_wr_end;
  logic [DATA_W-1:0]   app_wr_data;
  logic [MASK_W-1:0]   app_wr_mask;
  logic                app_wr_rdy;
  // controller read return and user read channel
  logic                app_rd_valid;
  logic [DATA_W-1:0]   app_rd_data;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_last;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_burst_cnt, cmd_wt_data, cmd_wt_mask,
    input  app_cmd_rdy, app_wr_rdy, app_rd_valid, app_rd_data,
    output cmd_rdy, app_cmd, app_cmd_en, app_addr, app_burst_number,
    output app_wr_en, app_wr_end, app_wr_data, app_wr_mask,
    output rd_valid, rd_data, rd_last
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_burst_cnt, cmd_wt_data, cmd_wt_mask,
    output app_cmd_rdy, app_wr_rdy, app_rd_valid, app_rd_data,
    input  cmd_rdy, app_cmd, app_cmd_en, app_addr, app_burst_number,
    input  app_wr_en, app_wr_end, app_wr_data, app_wr_mask,
    input  rd_valid, rd_data, rd_last
  );

endinterface

// File: rtl/ddr_rd_tracker.sv
// ddr_rd_tracker
// Counts outstanding read beats, keeps issued burst lengths in order and
// tags returned beats with a last flag.
//   i_issue/i_issue_len : read command accepted by controller, beats-1
//   i_beat_valid/data   : read beat from controller
//   o_cnt               : outstanding beats
//   o_rd_valid/data/last: registered read beat to user
module ddr_rd_tracker
  import ddr_cmd_pkg::*;
#(
  parameter int MAX_RD_BEATS = 128,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_issue,
  input  logic [BURST_W-1:0] i_issue_len,
  input  logic               i_beat_valid,
  input  logic [DATA_W-1:0]  i_beat_data,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_rd_valid,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_last
);

  localparam int AW = $clog2(MAX_RD_BEATS);

  // Every burst is at least one beat, so MAX_RD_BEATS entries always suffice.
  // Head is read asynchronously so rd_last can be decided in the beat's cycle.
  logic [BURST_W-1:0] r_len_mem [MAX_RD_BEATS];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_fifo_cnt;
  logic [BURST_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_last;

  logic               w_fifo_empty;
  logic               w_head_done;
  logic [CNT_W-1:0]   w_cnt_add;
  logic [CNT_W-1:0]   w_cnt_sub;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_RD_BEATS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_head_done  = i_beat_valid && !w_fifo_empty && (r_beat_cnt == r_len_mem[r_rd_ptr]);
  assign w_cnt_add    = i_issue ? CNT_W'(i_issue_len) + CNT_W'(1) : '0;
  // A beat with nothing outstanding is passed through but never decrements.
  assign w_cnt_sub    = (i_beat_valid && (r_cnt != '0)) ? CNT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (i_issue) begin
      r_len_mem[r_wr_ptr] <= i_issue_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_beat_cnt <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      if (i_issue) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_head_done) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_issue, w_head_done})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (i_beat_valid && !w_fifo_empty) begin
        r_beat_cnt <= w_head_done ? '0 : r_beat_cnt + 1'b1;
      end
      r_cnt      <= r_cnt + w_cnt_add - w_cnt_sub;
      r_rd_valid <= i_beat_valid;
      r_rd_data  <= i_beat_data;
      r_rd_last  <= w_head_done;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_last  = r_rd_last;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// ddr_cmd_issuer
// Pops commands from the clock-crossing FIFO and issues them on the DDR3
// controller native interface; reads are throttled by an outstanding-beat
// budget, returned read beats are tagged with rd_last.
//   clk, rst      : controller user clock, synchronous active-high reset
//   calib_done    : controller calibration complete
//   bus (master)  : FIFO pop, controller cmd/wr/rd channels, user read channel
//   wr_burst_err  : sticky, a write arrived with burst_cnt != 0
//   busy          : FSM not idle or reads outstanding
// Optional: DDR_CMD_STAT_EN adds stat_wr_cnt/stat_rd_cnt/stat_stall_cnt.
module ddr_cmd_issuer
  import ddr_cmd_pkg::*;
#(
  parameter int MAX_RD_BEATS = 128,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             calib_done,
  ddr_cmd_issuer_if.master bus,
  output logic             wr_burst_err,
  output logic             busy
`ifdef DDR_CMD_STAT_EN
  ,
  output logic [31:0]      stat_wr_cnt,
  output logic [31:0]      stat_rd_cnt,
  output logic [31:0]      stat_stall_cnt
`endif
);

  issuer_state_t      r_state;
  issuer_state_t      w_state_next;
  logic [2:0]         r_cmd;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_burst;
  logic [DATA_W-1:0]  r_wt_data;
  logic [MASK_W-1:0]  r_wt_mask;
  logic               r_is_wr;
  logic               r_wr_burst_err;
  logic               r_state_busy;

  logic               w_pop;
  logic               w_cmd_acc;
  logic               w_rd_issue;
  logic               w_rd_fits;
  logic [CNT_W:0]     w_rd_need;
  logic [CNT_W-1:0]   w_rd_cnt;
  logic               w_rd_valid;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_rd_last;
  logic               w_cmd_rdy;
  logic               w_app_cmd_en;
  logic               w_app_wr_en;

  // One extra bit so outstanding + new burst cannot wrap before the compare.
  assign w_rd_need  = (CNT_W+1)'(w_rd_cnt) + (CNT_W+1)'(bus.cmd_burst_cnt) + (CNT_W+1)'(1);
  assign w_rd_fits  = (w_rd_need <= (CNT_W+1)'(MAX_RD_BEATS));
  assign w_pop      = (r_state == ST_IDLE) && calib_done && bus.cmd_valid &&
                      (bus.cmd_type || w_rd_fits);
  assign w_cmd_acc  = (r_state == ST_ISSUE) && bus.app_cmd_rdy;
  assign w_rd_issue = w_cmd_acc && !r_is_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_CAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cmd_rdy    = 1'b0;
    w_app_cmd_en = 1'b0;
    w_app_wr_en  = 1'b0;
    case (r_state)
      ST_WAIT_CAL: begin
        if (calib_done) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        // calib_done loss is only acted on between commands.
        w_cmd_rdy = w_pop;
        if (!calib_done)  w_state_next = ST_WAIT_CAL;
        else if (w_pop)   w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_app_cmd_en = 1'b1;
        if (bus.app_cmd_rdy) w_state_next = r_is_wr ? ST_WDATA : ST_IDLE;
      end
      ST_WDATA: begin
        w_app_wr_en = 1'b1;
        if (bus.app_wr_rdy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd          <= '0;
      r_addr         <= '0;
      r_burst        <= '0;
      r_wt_data      <= '0;
      r_wt_mask      <= '0;
      r_is_wr        <= 1'b0;
      r_wr_burst_err <= 1'b0;
      r_state_busy   <= 1'b0;
    end else begin
      r_state_busy <= (w_state_next != ST_IDLE);
      if (w_pop) begin
        r_cmd     <= bus.cmd_type ? APP_CMD_WR : APP_CMD_RD;
        r_addr    <= bus.cmd_addr;
        // Writes are always a single beat regardless of the requested count.
        r_burst   <= bus.cmd_type ? '0 : bus.cmd_burst_cnt;
        r_wt_data <= bus.cmd_wt_data;
        r_wt_mask <= bus.cmd_wt_mask;
        r_is_wr   <= bus.cmd_type;
        if (bus.cmd_type && (bus.cmd_burst_cnt != '0)) begin
          r_wr_burst_err <= 1'b1;
        end
      end
    end
  end

  ddr_rd_tracker #(
    .MAX_RD_BEATS (MAX_RD_BEATS),
    .CNT_W        (CNT_W)
  ) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (w_rd_issue),
    .i_issue_len  (r_burst),
    .i_beat_valid (bus.app_rd_valid),
    .i_beat_data  (bus.app_rd_data),
    .o_cnt        (w_rd_cnt),
    .o_rd_valid   (w_rd_valid),
    .o_rd_data    (w_rd_data),
    .o_rd_last    (w_rd_last)
  );

  assign bus.cmd_rdy          = w_cmd_rdy;
  assign bus.app_cmd          = r_cmd;
  assign bus.app_cmd_en       = w_app_cmd_en;
  assign bus.app_addr         = r_addr;
  assign bus.app_burst_number = r_burst;
  assign bus.app_wr_en        = w_app_wr_en;
  assign bus.app_wr_end       = w_app_wr_en;
  assign bus.app_wr_data      = r_wt_data;
  assign bus.app_wr_mask      = r_wt_mask;
  assign bus.rd_valid         = w_rd_valid;
  assign bus.rd_data          = w_rd_data;
  assign bus.rd_last          = w_rd_last;
  assign wr_burst_err         = r_wr_burst_err;
  assign busy                 = r_state_busy || (w_rd_cnt != '0);

`ifdef DDR_CMD_STAT_EN
  logic [31:0] r_stat_wr_cnt;
  logic [31:0] r_stat_rd_cnt;
  logic [31:0] r_stat_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_wr_cnt    <= '0;
      r_stat_rd_cnt    <= '0;
      r_stat_stall_cnt <= '0;
    end else begin
      if (w_cmd_acc && r_is_wr)  r_stat_wr_cnt <= r_stat_wr_cnt + 1'b1;
      if (w_rd_issue)            r_stat_rd_cnt <= r_stat_rd_cnt + 1'b1;
      if (((r_state == ST_ISSUE) && !bus.app_cmd_rdy) ||
          ((r_state == ST_WDATA) && !bus.app_wr_rdy)) begin
        r_stat_stall_cnt <= r_stat_stall_cnt + 1'b1;
      end
    end
  end

  assign stat_wr_cnt    = r_stat_wr_cnt;
  assign stat_rd_cnt    = r_stat_rd_cnt;
  assign stat_stall_cnt = r_stat_stall_cnt;
`endif

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// tb_ddr_cmd_issuer
// Directed scoreboard bench: expected controller commands, write beats and
// user read beats are queued as stimulus is driven and compared when the
// DUT presents them.
module tb_ddr_cmd_issuer;
  import ddr_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic calib_done;
  logic wr_burst_err;
  logic busy;
`ifdef DDR_CMD_STAT_EN
  logic [31:0] stat_wr_cnt;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [26:0] addr;
    logic [5:0]  burst;
  } cmd_exp_t;

  cmd_exp_t     q_cmd[$];
  logic [143:0] q_wr[$];
  logic [128:0] q_rd[$];
  cmd_exp_t     m_cmd_e;
  logic [143:0] m_wr_e;
  logic [128:0] m_rd_e;

  ddr_cmd_issuer_if bus_if ();

  always #5 clk = ~clk;

  ddr_cmd_issuer #(
    .MAX_RD_BEATS (128),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .calib_done   (calib_done),
    .bus          (bus_if),
    .wr_burst_err (wr_burst_err),
    .busy         (busy)
`ifdef DDR_CMD_STAT_EN
    ,
    .stat_wr_cnt    (stat_wr_cnt),
    .stat_rd_cnt    (stat_rd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s (no transaction expected or bound expired)", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and wait (bounded) for the pop; returns one step after
  // the pop edge, i.e. while the DUT is in ISSUE.
  task automatic drive_cmd(input logic t, input logic [26:0] a, input logic [5:0] b,
                           input logic [127:0] d, input logic [15:0] m);
    cmd_exp_t e;
    bus_if.cmd_type      = t;
    bus_if.cmd_addr      = a;
    bus_if.cmd_burst_cnt = b;
    bus_if.cmd_wt_data   = d;
    bus_if.cmd_wt_mask   = m;
    bus_if.cmd_valid     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus_if.cmd_rdy) begin
        e.cmd   = t ? 3'b000 : 3'b001;
        e.addr  = a;
        e.burst = t ? 6'd0 : b;
        q_cmd.push_back(e);
        if (t) q_wr.push_back({d, m});
        tick();
        bus_if.cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    fail_now("cmd_pop_timeout");
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last);
    bus_if.app_rd_valid = 1'b1;
    bus_if.app_rd_data  = d;
    q_rd.push_back({d, last});
    tick();
    bus_if.app_rd_valid = 1'b0;
  endtask

  // Monitor: compare every handshake against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.app_cmd_en && bus_if.app_cmd_rdy) begin
        if (q_cmd.size() == 0) fail_now("cmd_unexpected");
        else begin
          m_cmd_e = q_cmd.pop_front();
          $display("cmd  type=%0h addr=%0h burst=%0d", bus_if.app_cmd, bus_if.app_addr,
                   bus_if.app_burst_number);
          check("app_cmd",   bus_if.app_cmd,          m_cmd_e.cmd);
          check("app_addr",  bus_if.app_addr,         m_cmd_e.addr);
          check("app_burst", bus_if.app_burst_number, m_cmd_e.burst);
        end
      end
      if (bus_if.app_wr_en && bus_if.app_wr_rdy) begin
        if (q_wr.size() == 0) fail_now("wr_unexpected");
        else begin
          m_wr_e = q_wr.pop_front();
          $display("wr   data=%0h mask=%0h", bus_if.app_wr_data, bus_if.app_wr_mask);
          check("app_wr_data", bus_if.app_wr_data, m_wr_e[143:16]);
          check("app_wr_mask", bus_if.app_wr_mask, m_wr_e[15:0]);
          check("app_wr_end",  bus_if.app_wr_end,  1'b1);
        end
      end
      if (bus_if.rd_valid) begin
        if (q_rd.size() == 0) fail_now("rd_unexpected");
        else begin
          m_rd_e = q_rd.pop_front();
          $display("rd   data=%0h last=%0b", bus_if.rd_data, bus_if.rd_last);
          check("rd_data", bus_if.rd_data, m_rd_e[128:1]);
          check("rd_last", bus_if.rd_last, m_rd_e[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b1;
    calib_done           = 1'b0;
    bus_if.cmd_valid     = 1'b0;
    bus_if.cmd_type      = 1'b0;
    bus_if.cmd_addr      = '0;
    bus_if.cmd_burst_cnt = '0;
    bus_if.cmd_wt_data   = '0;
    bus_if.cmd_wt_mask   = '0;
    bus_if.app_cmd_rdy   = 1'b1;
    bus_if.app_wr_rdy    = 1'b0;
    bus_if.app_rd_valid  = 1'b0;
    bus_if.app_rd_data   = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    #1;
    check("rst_cmd_rdy",    bus_if.cmd_rdy,    1'b0);
    check("rst_app_cmd_en", bus_if.app_cmd_en, 1'b0);
    check("rst_app_cmd",    bus_if.app_cmd,    3'b000);
    check("rst_app_addr",   bus_if.app_addr,   27'd0);
    check("rst_app_wr_en",  bus_if.app_wr_en,  1'b0);
    check("rst_rd_valid",   bus_if.rd_valid,   1'b0);
    check("rst_rd_last",    bus_if.rd_last,    1'b0);
    check("rst_wr_burst_err", wr_burst_err,    1'b0);

    // No pops before calibration; write waits for app_wr_rdy.
    bus_if.cmd_type      = 1'b1;
    bus_if.cmd_addr      = 27'h0001000;
    bus_if.cmd_burst_cnt = 6'd0;
    bus_if.cmd_wt_data   = {16{8'hA5}};
    bus_if.cmd_wt_mask   = 16'h0003;
    bus_if.cmd_valid     = 1'b1;
    repeat (3) begin
      tick();
      #1;
      check("cmd_rdy_nocal", bus_if.cmd_rdy, 1'b0);
    end
    calib_done = 1'b1;
    #1;
    check("cmd_rdy_cal_edge", bus_if.cmd_rdy, 1'b0);
    tick();
    #1;
    check("cmd_rdy_after_cal", bus_if.cmd_rdy, 1'b1);
    q_cmd.push_back({3'b000, 27'h0001000, 6'd0});
    q_wr.push_back({{16{8'hA5}}, 16'h0003});
    tick();
    bus_if.cmd_valid = 1'b0;
    check("app_cmd_en_latency", bus_if.app_cmd_en, 1'b1);
    repeat (4) begin
      tick();
      check("wr_en_held",   bus_if.app_wr_en,   1'b1);
      check("wr_end_held",  bus_if.app_wr_end,  1'b1);
      check("wr_data_held", bus_if.app_wr_data, {16{8'hA5}});
      check("wr_mask_held", bus_if.app_wr_mask, 16'h0003);
    end
    tick();
    bus_if.app_wr_rdy = 1'b1;
    tick();
    check("wr_en_done",     bus_if.app_wr_en, 1'b0);
    check("wr_burst_err_0", wr_burst_err,     1'b0);

    // Read burst of 8 beats.
    drive_cmd(1'b0, 27'h0000200, 6'd7, '0, '0);
    tick();
    for (int i = 0; i < 8; i++) send_beat(128'hD000 + 128'(i), i == 7);
    repeat (3) tick();
    check("cnt_after_8", dut.w_rd_cnt, 8'd0);
    check("busy_idle_8", busy,         1'b0);

    // Budget exhaustion: two 64-beat reads fill the 128-beat budget.
    drive_cmd(1'b0, 27'h0000100, 6'd63, '0, '0);
    drive_cmd(1'b0, 27'h0000140, 6'd63, '0, '0);
    bus_if.cmd_type      = 1'b0;
    bus_if.cmd_addr      = 27'h0000180;
    bus_if.cmd_burst_cnt = 6'd63;
    bus_if.cmd_valid     = 1'b1;
    tick();
    #1;
    check("cnt_full",        dut.w_rd_cnt,   8'd128);
    check("cmd_rdy_blocked", bus_if.cmd_rdy, 1'b0);
    tick();
    check("cmd_rdy_blocked2", bus_if.cmd_rdy, 1'b0);
    for (int j = 0; j < 63; j++) send_beat(128'hE000 + 128'(j), 1'b0);
    #1;
    check("cmd_rdy_blocked_63", bus_if.cmd_rdy, 1'b0);
    send_beat(128'hE000 + 128'd63, 1'b1);
    #1;
    check("cmd_rdy_unblocked", bus_if.cmd_rdy, 1'b1);
    drive_cmd(1'b0, 27'h0000180, 6'd63, '0, '0);
    tick();
    for (int j = 0; j < 128; j++) send_beat(128'hF000 + 128'(j), (j == 63) || (j == 127));
    repeat (3) tick();
    check("busy_idle_128", busy, 1'b0);

    // Write with a non-zero burst count.
    drive_cmd(1'b1, 27'h0002000, 6'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hF0F0);
    tick();
    tick();
    check("wr_burst_err_set", wr_burst_err, 1'b1);

    // Read accepted in the same cycle a beat returns: 5 + 4 - 1 = 8.
    drive_cmd(1'b0, 27'h0000300, 6'd4, '0, '0);
    tick();
    drive_cmd(1'b0, 27'h0000340, 6'd3, '0, '0);
    send_beat(128'hC000, 1'b0);
    check("cnt_net", dut.w_rd_cnt, 8'd8);
    for (int j = 1; j < 5; j++) send_beat(128'hC000 + 128'(j), j == 4);
    for (int j = 0; j < 4; j++) send_beat(128'hC100 + 128'(j), j == 3);
    repeat (3) tick();
    check("busy_idle_net", busy, 1'b0);
    check("wr_burst_err_sticky", wr_burst_err, 1'b1);

    // Stray beat with nothing outstanding: passed through, no last.
    send_beat(128'hBAD0, 1'b0);
    repeat (3) tick();
    check("cnt_underflow", dut.w_rd_cnt, 8'd0);
    check("q_cmd_empty", 144'(q_cmd.size()), 144'd0);
    check("q_wr_empty",  144'(q_wr.size()),  144'd0);
    check("q_rd_empty",  144'(q_rd.size()),  144'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_issuer.md
Name: ddr_cmd_issuer

Overview:
- Pop-side consumer of the clock-crossing command FIFO; runs entirely in the DDR controller user clock domain.
- Takes one 178-bit command (type, 27-bit address, 6-bit burst count, 128-bit write data, 16-bit mask) and drives the DDR3 controller native interface: command/address and write-data channels.
- Tracks outstanding read beats, tags returned read data with a last flag, and throttles new reads when the outstanding budget is exhausted.

Parameters:
- MAX_RD_BEATS, 128, maximum read beats in flight (sum of burst_cnt+1 over issued, not-yet-returned reads); must be ≥64.
- CNT_W, 8, width of the outstanding-beat counter; must satisfy 2^CNT_W > MAX_RD_BEATS.

Ports:
- clk  in  1  controller user clock
- rst  in  1  synchronous active-high reset
- calib_done  in  1  controller init/calibration complete
- cmd_valid  in  1  FIFO not empty
- cmd_rdy  out  1  pop strobe; FIFO pops when cmd_valid && cmd_rdy
- cmd_type  in  1  1 = write, 0 = read
- cmd_addr  in  27  byte-independent controller address
- cmd_burst_cnt  in  6  beats minus 1
- cmd_wt_data  in  128  write beat
- cmd_wt_mask  in  16  byte mask, 1 = masked
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_cmd_en  out  1  command strobe
- app_addr  out  27  command address
- app_burst_number  out  6  beats minus 1
- app_cmd_rdy  in  1  controller accepts command when high with app_cmd_en
- app_wr_en  out  1  write data valid
- app_wr_end  out  1  last write beat (always equals app_wr_en)
- app_wr_data  out  128  write data
- app_wr_mask  out  16  write mask
- app_wr_rdy  in  1  controller accepts data
- app_rd_valid  in  1  read beat from controller
- app_rd_data  in  128  read data
- rd_valid  out  1  read beat to user
- rd_data  out  128  registered copy of app_rd_data
- rd_last  out  1  final beat of the current read burst
- wr_burst_err  out  1  sticky: a write arrived with burst_cnt≠0
- busy  out  1  FSM not in IDLE, or reads outstanding

Behaviour:
- Reset: all outputs 0; FSM=WAIT_CAL; outstanding counter=0; wr_burst_err=0. Reset mid-burst discards the burst and the counter; no recovery of in-flight data.
- States: WAIT_CAL → IDLE when calib_done=1. IDLE: cmd_rdy=1 iff cmd_valid and (cmd_type=1, or outstanding+burst_cnt+1 ≤ MAX_RD_BEATS). Pop latches all fields into holding registers → ISSUE.
- ISSUE: app_cmd_en=1 with registered fields; hold stable until app_cmd_rdy=1. Read → IDLE. Write → WDATA.
- WDATA: app_wr_en=app_wr_end=1 with latched data/mask until app_wr_rdy=1 → IDLE.
- Writes always carry exactly one beat: app_burst_number forced to 0; a write with burst_cnt≠0 sets wr_burst_err (cleared only by rst).
- Issue latency: pop in cycle N, app_cmd_en in N+1. Minimum 2 cycles/read, 3 cycles/write.
- Outstanding counter: += burst_cnt+1 on read command acceptance (app_cmd_en && app_cmd_rdy); −=1 per app_rd_valid. Simultaneous add and subtract net in the same cycle. Underflow (app_rd_valid with counter 0) holds at 0 and produces rd_valid without rd_last.
- Read path: rd_valid/rd_data = app_rd_valid/app_rd_data delayed one cycle. Burst FIFO inside the tracker holds burst lengths in issue order; rd_last=1 on the beat completing the head burst, which then pops.
- A read is never held off by a pending write.
- calib_done falling: finish the current state, then return to WAIT_CAL from IDLE.

Optional Feature:
- DDR_CMD_STAT_EN: adds outputs stat_wr_cnt[31:0], stat_rd_cnt[31:0] (accepted commands) and stat_stall_cnt[31:0] (cycles in ISSUE/WDATA with rdy low). All are wrapping counters, cleared by rst.
- Without the macro: ports and logic are absent.

Decomposition:
- Package ddr_cmd_pkg: APP_CMD_WR=3'b000, APP_CMD_RD=3'b001, ADDR_W=27, BURST_W=6, DATA_W=128, MASK_W=16, FSM state enum.
- Sub-module: ddr_rd_tracker. Contains the outstanding counter, the burst-length FIFO (depth MAX_RD_BEATS) and rd_last generation.

Test Plan:
- calib_done=0 with cmd_valid=1 → cmd_rdy stays 0; raise calib_done → pop next cycle, app_cmd_en one cycle later.
- Write addr=0x0001000, data=0xA5…A5, mask=0x0003, app_wr_rdy low 4 cycles → app_cmd=000 and burst 0; data/mask held stable until the rdy handshake; wr_burst_err=0.
- Read burst_cnt=7, controller returns 8 beats → eight rd_valid pulses, rd_last only on the 8th, counter back to 0.
- Reads of burst_cnt=63 back-to-back with no return data → third read blocked (cmd_rdy=0) at counter=128; returning 64 beats unblocks it.
- Write with burst_cnt=3 → app_burst_number=0, wr_burst_err=1 and sticky.
- Read accepted while app_rd_valid beat arrives the same cycle → counter nets correctly (e.g. 5 + 4 − 1 = 8).
